// File: rtl/tm_err_pkg.sv
// Shared types and helpers for the truncated-multiplier error monitor.
package tm_err_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;

  localparam int TM_W     = 8;
  localparam int TM_SUM_W = 40;
  localparam int TM_CNT_W = 24;

  // Returns {overflowed, min(acc + inc, lim)}; callers pass lim = all-ones of their width.
  function automatic logic [64:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                          input logic [63:0] lim);
    logic [64:0] s;
    s = {1'b0, acc} + {1'b0, inc};
    return (s > {1'b0, lim}) ? {1'b1, lim} : s;
  endfunction

endpackage

// File: rtl/u_tm_err_mon8_stage.sv
// S2 slice: |exact - p_apx|, overshoot detect, saturating accumulate and counters.
// TM_ERR_MSE_EN adds a registered d^2 stage and the sum_sq accumulator.
module u_tm_err_stage
  import tm_err_pkg::*;
#(
  parameter int W     = TM_W,
  parameter int SUM_W = TM_SUM_W,
  parameter int CNT_W = TM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             vld,
  input  logic [2*W-1:0]   exact,
  input  logic [2*W-1:0]   p_apx,
  output logic             pend,
  output logic [SUM_W-1:0] sum_abs,
`ifdef TM_ERR_MSE_EN
  output logic [SUM_W-1:0] sum_sq,
`endif
  output logic [2*W-1:0]   wce,
  output logic [CNT_W-1:0] n_mis,
  output logic [CNT_W-1:0] n_over,
  output logic             sat
);

  localparam logic [63:0] SUM_MAX = {{(64-SUM_W){1'b0}}, {SUM_W{1'b1}}};

  logic           over;
  logic [2*W-1:0] d;
  logic           acc_vld, acc_over;
  logic [2*W-1:0] acc_d;
  logic [64:0]    sa_nxt;

  assign over = p_apx > exact;
  assign d    = over ? (p_apx - exact) : (exact - p_apx);

`ifdef TM_ERR_MSE_EN
  logic [4*W-1:0] acc_sq;
  logic [64:0]    sq_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc_vld  <= 1'b0;
      acc_over <= 1'b0;
      acc_d    <= '0;
      acc_sq   <= '0;
    end else begin
      acc_vld  <= vld;
      acc_over <= over;
      acc_d    <= d;
      acc_sq   <= {{(2*W){1'b0}}, d} * {{(2*W){1'b0}}, d};
    end
  end

  assign pend   = acc_vld;
  assign sq_nxt = sat_add(64'(sum_sq), 64'(acc_sq), SUM_MAX);
`else
  assign acc_vld  = vld;
  assign acc_over = over;
  assign acc_d    = d;
  assign pend     = 1'b0;
`endif

  assign sa_nxt = sat_add(64'(sum_abs), 64'(acc_d), SUM_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sum_abs <= '0;
      wce     <= '0;
      n_mis   <= '0;
      n_over  <= '0;
      sat     <= 1'b0;
`ifdef TM_ERR_MSE_EN
      sum_sq  <= '0;
`endif
    end else if (acc_vld) begin
      sum_abs <= sa_nxt[SUM_W-1:0];
      if (acc_d > wce) wce <= acc_d;
      if (acc_d != '0) n_mis <= n_mis + 1'b1;
      if (acc_over) n_over <= n_over + 1'b1;
`ifdef TM_ERR_MSE_EN
      sum_sq  <= sq_nxt[SUM_W-1:0];
      sat     <= sat | sa_nxt[64] | (|sa_nxt[63:SUM_W]) | sq_nxt[64] | (|sq_nxt[63:SUM_W]);
`else
      // upper bits are zero while clamped; folding them in keeps every bit observed
      sat     <= sat | sa_nxt[64] | (|sa_nxt[63:SUM_W]);
`endif
    end
  end

endmodule

// File: rtl/u_tm_err_mon8.sv
// Error monitor for the 8x8 truncated multiplier: run control FSM plus S1 exact-product stage.
// Optional macro TM_ERR_MSE_EN adds the sum_sq output and one extra pipeline stage.
module u_tm_err_mon8
  import tm_err_pkg::*;
#(
  parameter int W     = TM_W,
  parameter int SUM_W = TM_SUM_W,
  parameter int CNT_W = TM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_cfg,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   p_apx,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_abs,
`ifdef TM_ERR_MSE_EN
  output logic [SUM_W-1:0] sum_sq,
`endif
  output logic [2*W-1:0]   wce,
  output logic [CNT_W-1:0] n_mis,
  output logic [CNT_W-1:0] n_over,
  output logic             sat
);

  fsm_t           state;
  logic [CNT_W-1:0] n_left;
  logic           acc, pend;
  logic           s1_vld;
  logic [2*W-1:0] s1_ex, s1_pa;

  // a start pulse wins over a same-cycle handshake so nothing leaks into the new run
  assign acc = in_valid && in_ready && !start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      n_left   <= '0;
    end else if (start) begin
      n_left   <= n_cfg;
      state    <= (n_cfg == '0) ? DONE : RUN;
      done     <= (n_cfg == '0);
      in_ready <= (n_cfg != '0);
      busy     <= (n_cfg != '0);
    end else begin
      case (state)
        RUN: if (acc) begin
          n_left <= n_left - 1'b1;
          if (n_left == CNT_W'(1)) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: if (!s1_vld && !pend) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) s1_vld <= 1'b0;
    else                 s1_vld <= acc;
    s1_ex <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
    s1_pa <= p_apx;
  end

  u_tm_err_stage #(.W(W), .SUM_W(SUM_W), .CNT_W(CNT_W)) u_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .vld     (s1_vld),
    .exact   (s1_ex),
    .p_apx   (s1_pa),
    .pend    (pend),
    .sum_abs (sum_abs),
`ifdef TM_ERR_MSE_EN
    .sum_sq  (sum_sq),
`endif
    .wce     (wce),
    .n_mis   (n_mis),
    .n_over  (n_over),
    .sat     (sat)
  );

endmodule

// File: tb/tb_u_tm_err_mon8.sv
// Randomized self-checking bench for u_tm_err_mon8 with a sample-list reference model.
module tb_u_tm_err_mon8;
  localparam int W = 8, SUM_W = 40, CNT_W = 24;
`ifdef TM_ERR_MSE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam longint SMAX = (longint'(1) << SUM_W) - 1;

  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [CNT_W-1:0] n_cfg = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [2*W-1:0] p_apx = '0;
  logic in_ready, busy, done, sat, s_in_ready, s_busy, s_done, s_sat;
  logic [SUM_W-1:0] sum_abs;
  logic [16:0] s_sum_abs;
  logic [2*W-1:0] wce, s_wce;
  logic [CNT_W-1:0] n_mis, n_over, s_n_mis, s_n_over;
`ifdef TM_ERR_MSE_EN
  logic [SUM_W-1:0] sum_sq;
  logic [16:0] s_sum_sq;
`endif

  int n_chk = 0, n_pass = 0;
  int sa[$], sb[$], sp[$];   // directed source samples
  int ma[$], mb[$], mp[$];   // samples actually accepted

  always #5 clk = ~clk;

  u_tm_err_mon8 #(.W(W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_cfg(n_cfg), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .p_apx(p_apx), .busy(busy), .done(done),
    .sum_abs(sum_abs),
`ifdef TM_ERR_MSE_EN
    .sum_sq(sum_sq),
`endif
    .wce(wce), .n_mis(n_mis), .n_over(n_over), .sat(sat));

  u_tm_err_mon8 #(.W(W), .SUM_W(17), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .n_cfg(n_cfg), .in_valid(in_valid),
    .in_ready(s_in_ready), .a(a), .b(b), .p_apx(p_apx), .busy(s_busy), .done(s_done),
    .sum_abs(s_sum_abs),
`ifdef TM_ERR_MSE_EN
    .sum_sq(s_sum_sq),
`endif
    .wce(s_wce), .n_mis(s_n_mis), .n_over(s_n_over), .sat(s_sat));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // call at a negedge; returns at the negedge after the start edge
  task automatic do_start(input int n);
    start = 1; n_cfg = CNT_W'(n); in_valid = 0;
    ma.delete(); mb.delete(); mp.delete();
    @(negedge clk);
    start = 0;
  endtask

  task automatic feed(input int n, input int gap_pct, input bit directed);
    int cnt = 0, cyc = 0, ex;
    while (cnt < n && cyc < 5000) begin
      if ($urandom_range(99) < gap_pct) in_valid = 0;
      else begin
        in_valid = 1;
        if (directed) begin
          a = W'(sa[cnt]); b = W'(sb[cnt]); p_apx = 16'(sp[cnt]);
        end else begin
          a = W'($urandom); b = W'($urandom); ex = a * b;
          case ($urandom_range(3))
            0: p_apx = 16'(ex);
            1: p_apx = (ex > 65535 - 300) ? 16'hFFFF : 16'(ex + $urandom_range(300));
            2: p_apx = (ex < 300) ? 16'd0 : 16'(ex - $urandom_range(300));
            default: p_apx = 16'($urandom);
          endcase
        end
      end
      if (in_valid && in_ready) begin
        ma.push_back(a); mb.push_back(b); mp.push_back(p_apx); cnt++;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 0;
    if (cyc >= 5000) chk("feed_timeout", cnt, n);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_done_lat"}, k, LAT);
  endtask

  task automatic check_stats(input string tag);
    longint s = 0, m = 0, ex, d, q = 0;
    int mis = 0, ov = 0;
    foreach (ma[i]) begin
      ex = ma[i] * mb[i];
      if (mp[i] > ex) begin d = mp[i] - ex; ov++; end
      else d = ex - mp[i];
      s += d; q += d * d;
      if (d > m) m = d;
      if (d != 0) mis++;
    end
    chk({tag, "_sum"}, sum_abs, (s > SMAX) ? SMAX : s);
    chk({tag, "_wce"}, wce, m);
    chk({tag, "_mis"}, n_mis, mis);
    chk({tag, "_over"}, n_over, ov);
    chk({tag, "_busy"}, busy, 0);
`ifdef TM_ERR_MSE_EN
    chk({tag, "_sumsq"}, sum_sq, (q > SMAX) ? SMAX : q);
    chk({tag, "_sat"}, sat, (s > SMAX || q > SMAX) ? 1 : 0);
`else
    chk({tag, "_sat"}, sat, (s > SMAX) ? 1 : 0);
`endif
  endtask

  task automatic run_dir(input string tag, input int n, input int gap_pct);
    do_start(n);
    chk({tag, "_busy_run"}, busy, 1);
    feed(n, gap_pct, 1);
    chk({tag, "_rdy_off"}, in_ready, 0);
    wait_done(tag);
    check_stats(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);      chk("rst_sat", sat, 0);
    chk("rst_sum", sum_abs, 0);    chk("rst_wce", wce, 0);
    chk("rst_mis", n_mis, 0);      chk("rst_over", n_over, 0);
    rst_n = 1; @(negedge clk);

    sa = '{3, 255, 0, 16}; sb = '{5, 255, 7, 16}; sp = '{15, 65025, 0, 256};
    run_dir("exact", 4, 30);
    chk("exact_sum_lit", sum_abs, 0); chk("exact_mis_lit", n_mis, 0);

    sa = '{255, 2}; sb = '{255, 3}; sp = '{16'hF800, 0};
    run_dir("err", 2, 0);
    chk("err_sum_lit", sum_abs, 1543); chk("err_wce_lit", wce, 1537); chk("err_mis_lit", n_mis, 2);

    sa = '{1}; sb = '{1}; sp = '{4};
    run_dir("ovr", 1, 0);
    chk("ovr_n_lit", n_over, 1); chk("ovr_sum_lit", sum_abs, 3); chk("ovr_wce_lit", wce, 3);

    do_start(100);
    feed(100, 40, 0);
    chk("rand_cnt", ma.size(), 100);
    chk("rand_rdy_off", in_ready, 0);
    wait_done("rand");
    check_stats("rand");

    do_start(37);
    feed(37, 0, 0);
    wait_done("rand2");
    check_stats("rand2");

    // abort: sample 5 is still in flight when the new start lands
    sa = '{255, 255, 255, 255, 255}; sb = '{255, 255, 255, 255, 255}; sp = '{0, 0, 0, 0, 0};
    do_start(10);
    feed(5, 0, 1);
    sa = '{2}; sb = '{3}; sp = '{0};
    run_dir("abort", 1, 0);
    chk("abort_sum_lit", sum_abs, 6); chk("abort_mis_lit", n_mis, 1);

    do_start(0);
    chk("zero_done", done, 1); chk("zero_busy", busy, 0);
    chk("zero_sum", sum_abs, 0); chk("zero_mis", n_mis, 0); chk("zero_wce", wce, 0);

    sa = '{255, 255, 255}; sb = '{255, 255, 255}; sp = '{0, 0, 0};
    do_start(5);
    feed(2, 0, 1);
    rst_n = 0; @(negedge clk); rst_n = 1;
    chk("mrst_ready", in_ready, 0); chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
    chk("mrst_sum", sum_abs, 0);    chk("mrst_mis", n_mis, 0); chk("mrst_wce", wce, 0);
    @(negedge clk);
    chk("mrst_sum2", sum_abs, 0);   chk("mrst_mis2", n_mis, 0);

    sa = '{0, 0, 0}; sb = '{0, 0, 0}; sp = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_dir("satw", 3, 0);
    chk("sat17_sum", s_sum_abs, 17'h1FFFF); chk("sat17_flag", s_sat, 1);
    chk("sat17_over", s_n_over, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
